// File: rtl/noc_mem_loader.sv
// rtl/noc_mem_loader.sv - byte-stream loader that fills nine tile memories one record per address
//
// Purpose: collects fixed-length records from a byte stream into per-tile
// instruction/data registers, then pulses init_mem once per record so all
// nine tiles write the same address. Runs DEPTH addresses, then reports done.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               single-cycle run request (honoured in IDLE/DONE only)
//   in_valid, in_byte   load stream; in_ready high while collecting
//   init_mem, address   one-cycle write strobe and common tile address
//   inst0..8, data0..8  per-tile instruction/data bytes
//   busy, done, err     run status; err is the sticky bad-record flag
//
// Build option: NOC_LOADER_CHECKSUM_EN adds a trailing checksum byte per
// record (19 bytes); records whose byte sum is non-zero are dropped and
// collected again for the same address.

module noc_mem_loader #(
   parameter int DEPTH = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_byte,
   output logic       in_ready,
   output logic       init_mem,
   output logic [7:0] address,
   output logic [7:0] inst0,
   output logic [7:0] inst1,
   output logic [7:0] inst2,
   output logic [7:0] inst3,
   output logic [7:0] inst4,
   output logic [7:0] inst5,
   output logic [7:0] inst6,
   output logic [7:0] inst7,
   output logic [7:0] inst8,
   output logic [7:0] data0,
   output logic [7:0] data1,
   output logic [7:0] data2,
   output logic [7:0] data3,
   output logic [7:0] data4,
   output logic [7:0] data5,
   output logic [7:0] data6,
   output logic [7:0] data7,
   output logic [7:0] data8,
   output logic       busy,
   output logic       done,
   output logic       err
);

`ifdef NOC_LOADER_CHECKSUM_EN
   localparam logic [4:0] LAST_IDX = 5'd18;
`else
   localparam logic [4:0] LAST_IDX = 5'd17;
`endif
   localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, DONE} state_t;

   state_t     state_q, state_d;
   logic [4:0] idx_q;
   logic [7:0] addr_q;
   logic [7:0] inst_q [9];
   logic [7:0] data_q [9];
   logic       in_ready_q, init_mem_q, busy_q, done_q;

   logic       accept, last_byte, rec_ok, run_start;

   assign accept    = in_ready_q && in_valid;
   assign last_byte = (idx_q == LAST_IDX);
   assign run_start = ((state_q == IDLE) || (state_q == DONE)) && start;

`ifdef NOC_LOADER_CHECKSUM_EN
   logic [7:0] sum_q;
   logic [7:0] rec_sum;
   logic       err_q;

   assign rec_sum = sum_q + in_byte;
   assign rec_ok  = (rec_sum == 8'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q <= 8'd0;
         err_q <= 1'b0;
      end else if (run_start) begin
         sum_q <= 8'd0;
         err_q <= 1'b0;
      end else if (accept) begin
         // accumulator restarts at every record boundary, good or bad
         sum_q <= last_byte ? 8'd0 : rec_sum;
         if (last_byte && !rec_ok) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign rec_ok = 1'b1;
   assign err    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = COLLECT;
         // a rejected record falls through and stays in COLLECT at the same address
         COLLECT:    if (accept && last_byte && rec_ok) state_d = COMMIT;
         COMMIT:     state_d = (addr_q == LAST_ADDR) ? DONE : COLLECT;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= 5'd0;
         addr_q     <= 8'd0;
         in_ready_q <= 1'b0;
         init_mem_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int t = 0; t < 9; t++) begin
            inst_q[t] <= 8'd0;
            data_q[t] <= 8'd0;
         end
      end else begin
         state_q <= state_d;
         // status outputs are registered from the next state so they line up with it
         in_ready_q <= (state_d == COLLECT);
         init_mem_q <= (state_d == COMMIT);
         busy_q     <= (state_d == COLLECT) || (state_d == COMMIT);
         done_q     <= (state_d == DONE);
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  idx_q  <= 5'd0;
                  addr_q <= 8'd0;
               end
            end
            COLLECT: begin
               if (accept) begin
                  // byte k goes to tile k/2: even k instruction, odd k data; the checksum byte is not stored
                  if (idx_q < 5'd18) begin
                     if (!idx_q[0]) inst_q[idx_q[4:1]] <= in_byte;
                     else           data_q[idx_q[4:1]] <= in_byte;
                  end
                  idx_q <= last_byte ? 5'd0 : idx_q + 5'd1;
               end
            end
            COMMIT: begin
               if (addr_q != LAST_ADDR) addr_q <= addr_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign init_mem = init_mem_q;
   assign address  = addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign inst0 = inst_q[0];
   assign inst1 = inst_q[1];
   assign inst2 = inst_q[2];
   assign inst3 = inst_q[3];
   assign inst4 = inst_q[4];
   assign inst5 = inst_q[5];
   assign inst6 = inst_q[6];
   assign inst7 = inst_q[7];
   assign inst8 = inst_q[8];
   assign data0 = data_q[0];
   assign data1 = data_q[1];
   assign data2 = data_q[2];
   assign data3 = data_q[3];
   assign data4 = data_q[4];
   assign data5 = data_q[5];
   assign data6 = data_q[6];
   assign data7 = data_q[7];
   assign data8 = data_q[8];

endmodule

// File: tb/tb_noc_mem_loader.sv
// tb/tb_noc_mem_loader.sv - scoreboard bench for noc_mem_loader (DEPTH=2 and DEPTH=256 instances)

module tb_noc_mem_loader;

`ifdef NOC_LOADER_CHECKSUM_EN
   localparam int RB = 19;
`else
   localparam int RB = 18;
`endif
   localparam int NI = 2;
   localparam int D0 = 2;
   localparam int D1 = 256;

   typedef struct packed {
      logic [7:0]       a;
      logic [17:0][7:0] b;
   } commit_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_byte = 8'd0;

   logic       rdy   [NI];
   logic       initm [NI];
   logic [7:0] addr  [NI];
   logic [7:0] inst  [NI][9];
   logic [7:0] dat   [NI][9];
   logic       busy  [NI];
   logic       done  [NI];
   logic       err   [NI];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      noc_mem_loader #(.DEPTH(g == 0 ? D0 : D1)) u_dut (
         .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
         .in_ready(rdy[g]), .init_mem(initm[g]), .address(addr[g]),
         .inst0(inst[g][0]), .inst1(inst[g][1]), .inst2(inst[g][2]),
         .inst3(inst[g][3]), .inst4(inst[g][4]), .inst5(inst[g][5]),
         .inst6(inst[g][6]), .inst7(inst[g][7]), .inst8(inst[g][8]),
         .data0(dat[g][0]), .data1(dat[g][1]), .data2(dat[g][2]),
         .data3(dat[g][3]), .data4(dat[g][4]), .data5(dat[g][5]),
         .data6(dat[g][6]), .data7(dat[g][7]), .data8(dat[g][8]),
         .busy(busy[g]), .done(done[g]), .err(err[g])
      );
   end

   // ---------------- reference model (record-level) ----------------
   int         m_addr [NI];
   bit         m_run  [NI];
   bit         m_done [NI];
   bit         m_err  [NI];
   logic [7:0] m_buf  [$];
   commit_t    exp_q  [NI][$];
   int         n_commit [NI];

   function automatic int depth_of(input int i);
      return (i == 0) ? D0 : D1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NI; i++) begin
         m_addr[i] = 0; m_run[i] = 0; m_done[i] = 0; m_err[i] = 0;
      end
      m_buf.delete();
   endfunction

   function automatic void model_start();
      if (!m_run[1]) m_buf.delete();
      for (int i = 0; i < NI; i++) begin
         if (!m_run[i]) begin
            m_run[i] = 1; m_done[i] = 0; m_err[i] = 0; m_addr[i] = 0;
         end
      end
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      int      s;
      bit      ok;
      commit_t c;
      m_buf.push_back(b);
      if (m_buf.size() == RB) begin
         s = 0;
         foreach (m_buf[k]) s += m_buf[k];
         ok = (RB == 18) || ((s % 256) == 0);
         for (int i = 0; i < NI; i++) begin
            if (m_run[i]) begin
               if (ok) begin
                  c.a = 8'(m_addr[i]);
                  for (int k = 0; k < 18; k++) c.b[k] = m_buf[k];
                  exp_q[i].push_back(c);
                  if (m_addr[i] == depth_of(i) - 1) begin
                     m_run[i] = 0; m_done[i] = 1;
                  end else begin
                     m_addr[i]++;
                  end
               end else begin
                  m_err[i] = 1;
               end
            end
         end
         m_buf.delete();
      end
   endfunction

   // ---------------- checking helpers ----------------
   task automatic finish_tb();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   endtask

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_zero();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_in_ready%0d", i), 144'(rdy[i]), 144'd0);
         chk($sformatf("rst_init_mem%0d", i), 144'(initm[i]), 144'd0);
         chk($sformatf("rst_address%0d", i), 144'(addr[i]), 144'd0);
         chk($sformatf("rst_busy%0d", i), 144'(busy[i]), 144'd0);
         chk($sformatf("rst_done%0d", i), 144'(done[i]), 144'd0);
         chk($sformatf("rst_err%0d", i), 144'(err[i]), 144'd0);
         for (int t = 0; t < 9; t++) begin
            chk($sformatf("rst_inst%0d_%0d", t, i), 144'(inst[i][t]), 144'd0);
            chk($sformatf("rst_data%0d_%0d", t, i), 144'(dat[i][t]), 144'd0);
         end
      end
   endtask

   task automatic check_status(input string tag);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s_address%0d", tag, i), 144'(addr[i]), 144'(m_addr[i]));
         chk($sformatf("%s_busy%0d", tag, i), 144'(busy[i]), 144'(m_run[i]));
         chk($sformatf("%s_done%0d", tag, i), 144'(done[i]), 144'(m_done[i]));
         chk($sformatf("%s_err%0d", tag, i), 144'(err[i]), 144'(m_err[i]));
      end
   endtask

   // ---------------- monitor ----------------
   logic             prev_init [NI] = '{1'b0, 1'b0};
   commit_t          mon_e;
   logic [17:0][7:0] mon_act;

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (initm[i]) begin
            n_commit[i]++;
            chk($sformatf("init_mem_single_cycle%0d", i), 144'(prev_init[i]), 144'd0);
            if (exp_q[i].size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_init_mem dut%0d address=0x%0h expected=no_commit", i, addr[i]);
            end else begin
               mon_e = exp_q[i].pop_front();
               for (int t = 0; t < 9; t++) begin
                  mon_act[2*t]   = inst[i][t];
                  mon_act[2*t+1] = dat[i][t];
               end
               chk($sformatf("commit_address%0d", i), 144'(addr[i]), 144'(mon_e.a));
               chk($sformatf("commit_bytes%0d_a%0d", i, mon_e.a), 144'(mon_act), 144'(mon_e.b));
            end
         end
         prev_init[i] = initm[i];
      end
   end

   // ---------------- stimulus ----------------
`ifdef NOC_LOADER_CHECKSUM_EN
   logic [7:0] cs_delta = 8'd0;
`endif

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < NI; i++) n_commit[i] = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      model_start();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
      bit ok;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_byte = b; start = st;
      if (st) model_start();
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk); ok = rdy[1];
         @(posedge clk); #1; start = 1'b0;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL handshake_timeout in_ready=0 required=1 byte=0x%0h", b);
         finish_tb();
      end
      model_byte(b);
   endtask

   // gmode 0: back-to-back, 1: in_valid toggles every cycle, 2: random gaps
   task automatic send_record(input logic [17:0][7:0] r, input int gmode, input int st_at);
      int gap;
      for (int k = 0; k < 18; k++) begin
         gap = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
         send_byte(r[k], gap, (k == st_at));
      end
`ifdef NOC_LOADER_CHECKSUM_EN
      begin
         logic [7:0] s;
         s = 8'd0;
         for (int k = 0; k < 18; k++) s = s + r[k];
         send_byte(8'(8'd0 - s) + cs_delta, 0, 1'b0);
      end
`endif
   endtask

   function automatic logic [17:0][7:0] rand_rec();
      logic [17:0][7:0] r;
      for (int k = 0; k < 18; k++) r[k] = 8'($urandom);
      return r;
   endfunction

   initial begin
      logic [17:0][7:0] r;
      for (int i = 0; i < NI; i++) n_commit[i] = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_zero();
      check_status("idle");

      // two back-to-back records of an incrementing byte pattern
      pulse_start();
      for (int rec = 0; rec < 2; rec++) begin
         for (int k = 0; k < 18; k++) r[k] = 8'(rec * 18 + k);
         send_record(r, 0, -1);
      end
      idle(2);
      check_status("incr");
      chk("incr_commits_d2", 144'(n_commit[0]), 144'd2);
      chk("incr_done_d2", 144'(done[0]), 144'd1);
      chk("incr_busy_d2", 144'(busy[0]), 144'd0);
      chk("incr_inst0_d2", 144'(inst[0][0]), 144'h12);
      chk("incr_data8_d2", 144'(dat[0][8]), 144'h23);

      // toggled in_valid, then a start pulse in the middle of a record
      do_reset();
      pulse_start();
      send_record(rand_rec(), 1, -1);
      send_record(rand_rec(), 0, 5);
      idle(2);
      check_status("toggle");

      // reset mid-record at address 3, then a fresh run
      do_reset();
      pulse_start();
      for (int rec = 0; rec < 3; rec++) send_record(rand_rec(), 2, -1);
      r = rand_rec();
      for (int k = 0; k <= 10; k++) send_byte(r[k], 0, 1'b0);
      chk("pre_reset_address_d256", 144'(addr[1]), 144'd3);
      do_reset();
      check_zero();
      idle(3);
      check_status("after_reset");
      pulse_start();
      send_record(rand_rec(), 0, -1);
      idle(2);
      check_status("restart");
      chk("restart_commits_d256", 144'(n_commit[1]), 144'd1);

`ifdef NOC_LOADER_CHECKSUM_EN
      // good checksum, bad checksum (dropped, err), retry at same address
      do_reset();
      pulse_start();
      for (int k = 0; k < 18; k++) r[k] = 8'h01;
      send_record(r, 0, -1);
      cs_delta = 8'd1;
      send_record(r, 0, -1);
      cs_delta = 8'd0;
      idle(2);
      check_status("cs_bad");
      chk("cs_bad_err", 144'(err[1]), 144'd1);
      chk("cs_bad_address", 144'(addr[1]), 144'd1);
      send_record(r, 0, -1);
      idle(2);
      check_status("cs_retry");
      chk("cs_retry_commits", 144'(n_commit[1]), 144'd2);
`endif

      // full DEPTH=256 run
      do_reset();
      pulse_start();
      for (int rec = 0; rec < D1; rec++) send_record(rand_rec(), (rec % 4 == 0) ? 2 : 0, -1);
      idle(5);
      check_status("full");
      chk("full_commits_d256", 144'(n_commit[1]), 144'd256);
      chk("full_address_d256", 144'(addr[1]), 144'hFF);
      chk("full_done_d256", 144'(done[1]), 144'd1);
      chk("full_in_ready_d256", 144'(rdy[1]), 144'd0);

      for (int i = 0; i < NI; i++)
         chk($sformatf("scoreboard_empty%0d", i), 144'(exp_q[i].size()), 144'd0);
      finish_tb();
   end

   initial begin
      #500000;
      n_tests++; n_fail++;
      $display("FAIL watchdog elapsed=500000ns required=finish_before_limit");
      finish_tb();
   end

endmodule

// File: doc/noc_mem_loader.md
NOC_MEM_LOADER -- requirements
Module: noc_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of memory addresses loaded per run (1..256).
REQ-002 SHALL have port clk  input  1  the only clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load run.
REQ-005 SHALL have port in_valid  input  1  in_byte carries a valid stream byte.
REQ-006 SHALL have port in_byte  input  8  load-stream byte.
REQ-007 SHALL have port in_ready  output  1  loader accepts in_byte this cycle.
REQ-008 SHALL have port init_mem  output  1  write strobe to all nine tiles.
REQ-009 SHALL have port address  output  8  common memory address for all tiles.
REQ-010 SHALL have ports inst0..inst8  output  8 each  instruction byte for tile 0..8.
REQ-011 SHALL have ports data0..data8  output  8 each  data byte for tile 0..8.
REQ-012 SHALL have port busy  output  1  run in progress.
REQ-013 SHALL have port done  output  1  run completed; held until next start.
REQ-014 SHALL have port err  output  1  sticky record error (checksum build only; else tied 0).

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, COMMIT, DONE.
REQ-016 SHALL, in IDLE or DONE, on start=1: clear done, err, byte index, address counter; go to COLLECT next cycle.
REQ-017 SHALL ignore start while in COLLECT or COMMIT.
REQ-018 SHALL drive in_ready=1 only in COLLECT; a byte is accepted when in_valid=1 and in_ready=1.
REQ-019 SHALL treat each record as 18 bytes, index k=0..17: tile=k/2; even k loads inst<tile>, odd k loads data<tile>.
REQ-020 SHALL load the addressed inst/data output register in the cycle the byte is accepted; other registers hold.
REQ-021 SHALL enter COMMIT in the cycle after the last record byte is accepted; byte index returns to 0.
REQ-022 SHALL drive init_mem=1 for exactly one cycle, in COMMIT only, with address = current address counter and all 18 byte outputs stable.
REQ-023 SHALL, on leaving COMMIT: if address = DEPTH-1 go to DONE, else increment address and return to COLLECT.
REQ-024 SHALL hold address, inst*, data* between commits; the counter SHALL never wrap past DEPTH-1.
REQ-025 SHALL drive busy=1 in COLLECT and COMMIT, done=1 in DONE only.
REQ-026 SHALL stall with no state change while in_valid=0 in COLLECT; no timeout.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, enter IDLE and clear all outputs to 0 (in_ready, init_mem, address, inst*, data*, busy, done, err), byte index and any checksum accumulator.
REQ-028 SHALL abandon a partial record or pending commit on reset mid-run; init_mem SHALL NOT assert in the cycle following reset.

Configuration
REQ-029 SHALL support macro NOC_LOADER_CHECKSUM_EN; when defined, each record is 19 bytes, byte 18 being a checksum.
REQ-030 SHALL, with the macro defined, accept a record only if the 8-bit sum mod 256 of all 19 bytes equals 0; the check precedes COMMIT.
REQ-031 SHALL, on checksum mismatch: set err (sticky until start or reset), skip COMMIT, keep address unchanged, return to COLLECT for the same address.
REQ-032 SHALL, with the macro undefined, use 18-byte records, contain no checksum logic, and hold err at 0.

Verification
REQ-033 SHALL cover: DEPTH=2, start, 36 bytes 0x00..0x23 with in_valid=1 continuously -> two init_mem pulses at address 0 (inst0=0x00, data0=0x01, data8=0x11) and 1 (inst0=0x12, data8=0x23), then done=1, busy=0.
REQ-034 SHALL cover: in_valid toggled 1/0 every cycle during one record -> same output values as back-to-back; init_mem one cycle only.
REQ-035 SHALL cover: start asserted during COLLECT at byte 5 -> ignored; byte index and address unchanged.
REQ-036 SHALL cover: rst_n=0 for one cycle after byte 10 of record at address 3 -> all outputs 0, IDLE; no init_mem; fresh start reloads from address 0.
REQ-037 SHALL cover (macro defined): record of eighteen 0x01 bytes + checksum 0xEE -> commit; same record with checksum 0xEF -> err=1, no init_mem, retry at same address succeeds with 0xEE, err stays 1.
REQ-038 SHALL cover: DEPTH=256 full run -> final init_mem at address 0xFF, no wrap to 0x00, done=1.
